// File: rtl/calc_pkg.sv
// Shared definitions for the calculator core arbiter: opcodes, FSM states, defaults.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam int unsigned DefaultTimeout = 64;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } calc_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not served last.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  // One-hot grant from the request pattern and the last-served id
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/calc_core_arbiter.sv
// Shares one multi-cycle calculator core between two requesters, one operation at a time.
module calc_core_arbiter #(
  parameter int unsigned width   = 8,
  parameter int unsigned timeout = calc_pkg::DefaultTimeout
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic [1:0]           req_valid_i,
  output logic [1:0]           req_ready_o,
  input  logic [2*width-1:0]   req_a_i,
  input  logic [2*width-1:0]   req_b_i,
  input  logic [3:0]           req_op_i,
  output logic                 core_start_o,
  output logic [width-1:0]     core_a_o,
  output logic [width-1:0]     core_b_o,
  output logic [1:0]           core_op_o,
  input  logic                 core_done_i,
  input  logic [2*width-1:0]   core_res_i,
  input  logic [2*width-1:0]   core_rem_i,
  output logic [1:0]           rsp_valid_o,
  input  logic [1:0]           rsp_ready_i,
  output logic [2*width-1:0]   rsp_res_o,
  output logic [2*width-1:0]   rsp_rem_o,
  output logic                 rsp_err_o,
  output logic                 busy_o
);

  import calc_pkg::*;

  localparam int unsigned CntW = $clog2(timeout);
  // Leaving WAIT as the counter steps to timeout-1 puts the response timeout cycles after start
  localparam logic [CntW-1:0] CntLast = CntW'(timeout - 2);

  calc_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 id_q, id_d;
  logic                 last_q, last_d;
  logic [width-1:0]     a_q, a_d, b_q, b_d;
  logic [1:0]           op_q, op_d;
  logic [2*width-1:0]   res_q, res_d, rem_q, rem_d;
  logic                 err_q, err_d;

  logic [1:0]           grant;
  logic [width-1:0]     win_a, win_b;
  logic [1:0]           win_op;

  rr_arbiter2 u_rr_arbiter2 (
    .req_i   (req_valid_i),
    .last_i  (last_q),
    .grant_o (grant)
  );

  assign win_a  = grant[1] ? req_a_i[width +: width] : req_a_i[0 +: width];
  assign win_b  = grant[1] ? req_b_i[width +: width] : req_b_i[0 +: width];
  assign win_op = grant[1] ? req_op_i[3:2] : req_op_i[1:0];

  // Next-state logic: accept, issue, wait for done or timeout, hold response until taken
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (|grant) begin
          id_d = grant[1];
          a_d  = win_a;
          b_d  = win_b;
          op_d = win_op;
          if (win_op == OP_DIV && win_b == '0) begin
            // Divide by zero is answered locally; the core never sees it
            res_d   = '1;
            rem_d   = {{width{1'b0}}, win_a};
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (core_done_i) begin
          res_d   = core_res_i;
          rem_d   = core_rem_i;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          res_d   = '0;
          rem_d   = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready_i[id_q]) begin
          last_d  = id_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latch registers with synchronous active-low reset
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;  // requester 0 wins the first tie
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o  = (state_q == StIdle) ? grant : 2'b00;
  assign core_start_o = (state_q == StIssue);
  assign core_a_o     = a_q;
  assign core_b_o     = b_q;
  assign core_op_o    = op_q;
  assign rsp_valid_o  = (state_q == StResp) ? {id_q, ~id_q} : 2'b00;
  assign rsp_res_o    = res_q;
  assign rsp_rem_o    = rem_q;
  assign rsp_err_o    = err_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_calc_core_arbiter.sv
// Directed bench for calc_core_arbiter with a small behavioural core model.
module tb_calc_core_arbiter;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [15:0] req_a_i, req_b_i;
  logic [3:0]  req_op_i;
  logic        core_start_o;
  logic [7:0]  core_a_o, core_b_o;
  logic [1:0]  core_op_o;
  logic        core_done_i;
  logic [15:0] core_res_i, core_rem_i;
  logic [1:0]  rsp_valid_o, rsp_ready_i;
  logic [15:0] rsp_res_o, rsp_rem_o;
  logic        rsp_err_o, busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int base;

  // Core model controls
  int          core_lat = 0;
  int          cd = 0;
  logic [7:0]  ma, mb;
  logic [1:0]  mop;
  logic        model_done = 1'b0;
  logic [15:0] model_res = 16'hDEAD;
  logic [15:0] model_rem = 16'hBEEF;
  logic        inj_done = 1'b0;

  calc_core_arbiter dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_op_i     (req_op_i),
    .core_start_o (core_start_o),
    .core_a_o     (core_a_o),
    .core_b_o     (core_b_o),
    .core_op_o    (core_op_o),
    .core_done_i  (core_done_i),
    .core_res_i   (core_res_i),
    .core_rem_i   (core_rem_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_res_o    (rsp_res_o),
    .rsp_rem_o    (rsp_rem_o),
    .rsp_err_o    (rsp_err_o),
    .busy_o       (busy_o)
  );

  always #5 clock_i = ~clock_i;

  assign core_done_i = model_done | inj_done;
  assign core_res_i  = model_res;
  assign core_rem_i  = model_rem;

  // Core model: counts starts, answers core_lat cycles after a start (never when core_lat is 0)
  always @(negedge clock_i) begin
    model_done = 1'b0;
    model_res  = 16'hDEAD;
    model_rem  = 16'hBEEF;
    if (core_start_o) begin
      n_starts = n_starts + 1;
      cd  = core_lat;
      ma  = core_a_o;
      mb  = core_b_o;
      mop = core_op_o;
    end else if (cd != 0) begin
      cd = cd - 1;
      if (cd == 0) begin
        model_done = 1'b1;
        model_rem  = 16'h0000;
        case (mop)
          2'd0: model_res = {8'd0, ma} + {8'd0, mb};
          2'd1: model_res = {8'd0, ma} - {8'd0, mb};
          2'd2: model_res = {8'd0, ma} * {8'd0, mb};
          default: begin
            model_res = {8'd0, ma / mb};
            model_rem = {8'd0, ma % mb};
          end
        endcase
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic wait_rsp(input int max);
    int n = 0;
    while (rsp_valid_o == 2'b00 && n < max) begin
      tick();
      n++;
    end
    check_eq("rsp_seen", 32'(rsp_valid_o != 2'b00), 1);
  endtask

  task automatic wait_ready(input int max);
    int n = 0;
    while (req_ready_o == 2'b00 && n < max) begin
      tick();
      n++;
    end
    check_eq("ready_seen", 32'(req_ready_o != 2'b00), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b0; req_valid_i = 2'b00; req_a_i = '0; req_b_i = '0; req_op_i = '0;
    rsp_ready_i = 2'b11;
    tick();
    tick();
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_rsp_valid", rsp_valid_o, 0);
    check_eq("rst_start", core_start_o, 0);
    check_eq("rst_core_a", core_a_o, 0);
    check_eq("rst_err", rsp_err_o, 0);
    reset_i = 1'b1;
    tick();

    // Single request: 12*5, core answers 8 cycles after start
    req_a_i = {8'd0, 8'd12}; req_b_i = {8'd0, 8'd5}; req_op_i = {2'd0, 2'd2};
    req_valid_i = 2'b01; core_lat = 8; base = n_starts;
    #1;
    check_eq("t1_ready", req_ready_o, 2'b01);
    tick();
    req_valid_i = 2'b00;
    check_eq("t1_start", core_start_o, 1);
    check_eq("t1_core_a", core_a_o, 12);
    check_eq("t1_core_b", core_b_o, 5);
    check_eq("t1_core_op", core_op_o, 2);
    check_eq("t1_busy", busy_o, 1);
    tick();
    check_eq("t1_start_once", core_start_o, 0);
    repeat (7) tick();
    check_eq("t1_not_yet", rsp_valid_o, 0);
    tick();
    check_eq("t1_rsp_valid", rsp_valid_o, 2'b01);
    check_eq("t1_res", rsp_res_o, 60);
    check_eq("t1_rem", rsp_rem_o, 0);
    check_eq("t1_err", rsp_err_o, 0);
    tick();
    check_eq("t1_idle_busy", busy_o, 0);
    check_eq("t1_idle_valid", rsp_valid_o, 0);
    check_eq("t1_starts", n_starts - base, 1);

    // Divide by zero from requester 1
    req_a_i = {8'd200, 8'd0}; req_b_i = 16'd0; req_op_i = {2'd3, 2'd0};
    req_valid_i = 2'b10; base = n_starts;
    #1;
    check_eq("dz_ready", req_ready_o, 2'b10);
    tick();
    req_valid_i = 2'b00;
    check_eq("dz_rsp_valid", rsp_valid_o, 2'b10);
    check_eq("dz_res", rsp_res_o, 16'hFFFF);
    check_eq("dz_rem", rsp_rem_o, 200);
    check_eq("dz_err", rsp_err_o, 1);
    check_eq("dz_start", core_start_o, 0);
    tick();
    check_eq("dz_busy", busy_o, 0);
    check_eq("dz_starts", n_starts - base, 0);

    // Contention: both valid, grants alternate starting with requester 0
    req_a_i = {8'd9, 8'd3}; req_b_i = {8'd2, 8'd4}; req_op_i = {2'd1, 2'd0};
    req_valid_i = 2'b11; core_lat = 3;
    #1;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_g;
      exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
      wait_ready(20);
      check_eq("ct_grant", req_ready_o, exp_g);
      tick();
      wait_rsp(20);
      check_eq("ct_rsp_valid", rsp_valid_o, exp_g);
      check_eq("ct_res", rsp_res_o, 7);
      check_eq("ct_err", rsp_err_o, 0);
      if (i == 3) req_valid_i = 2'b00;
      tick();
    end

    // Backpressure: response held, requester 1 waits for the handshake
    rsp_ready_i = 2'b00; req_valid_i = 2'b11; core_lat = 2;
    #1;
    check_eq("bp_ready0", req_ready_o, 2'b01);
    tick();
    req_valid_i = 2'b10;
    check_eq("bp_busy_ready", req_ready_o, 2'b00);
    wait_rsp(20);
    check_eq("bp_rsp_valid", rsp_valid_o, 2'b01);
    check_eq("bp_res", rsp_res_o, 7);
    repeat (5) begin
      tick();
      check_eq("bp_hold_valid", rsp_valid_o, 2'b01);
      check_eq("bp_hold_res", rsp_res_o, 7);
      check_eq("bp_hold_err", rsp_err_o, 0);
      check_eq("bp_hold_ready", req_ready_o, 2'b00);
    end
    rsp_ready_i = 2'b01;
    tick();
    check_eq("bp_ready1", req_ready_o, 2'b10);
    rsp_ready_i = 2'b11;
    tick();
    req_valid_i = 2'b00;
    wait_rsp(20);
    check_eq("bp_rsp1_valid", rsp_valid_o, 2'b10);
    check_eq("bp_rsp1_res", rsp_res_o, 7);
    tick();

    // Timeout: core never answers
    core_lat = 0;
    req_a_i = {8'd0, 8'd100}; req_b_i = {8'd0, 8'd7}; req_op_i = {2'd0, 2'd3};
    req_valid_i = 2'b01;
    #1;
    tick();
    req_valid_i = 2'b00;
    check_eq("to_start", core_start_o, 1);
    repeat (63) tick();
    check_eq("to_early", rsp_valid_o, 0);
    tick();
    check_eq("to_rsp_valid", rsp_valid_o, 2'b01);
    check_eq("to_res", rsp_res_o, 0);
    check_eq("to_rem", rsp_rem_o, 0);
    check_eq("to_err", rsp_err_o, 1);
    tick();
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    check_eq("to_late_valid", rsp_valid_o, 0);
    check_eq("to_late_busy", busy_o, 0);
    tick();
    check_eq("to_late_valid2", rsp_valid_o, 0);

    // Reset during WAIT abandons the operation
    req_a_i = {8'd0, 8'd12}; req_b_i = {8'd0, 8'd5}; req_op_i = {2'd0, 2'd2};
    req_valid_i = 2'b01;
    #1;
    tick();
    req_valid_i = 2'b00;
    tick();
    tick();
    tick();
    reset_i = 1'b0;
    tick();
    check_eq("mr_busy", busy_o, 0);
    check_eq("mr_rsp_valid", rsp_valid_o, 0);
    check_eq("mr_start", core_start_o, 0);
    check_eq("mr_core_a", core_a_o, 0);
    check_eq("mr_core_b", core_b_o, 0);
    check_eq("mr_core_op", core_op_o, 0);
    check_eq("mr_res", rsp_res_o, 0);
    check_eq("mr_rem", rsp_rem_o, 0);
    check_eq("mr_err", rsp_err_o, 0);
    reset_i = 1'b1;
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    check_eq("mr_done_ignored", rsp_valid_o, 0);
    check_eq("mr_done_busy", busy_o, 0);
    req_a_i = {8'd9, 8'd3}; req_b_i = {8'd2, 8'd4}; req_op_i = {2'd1, 2'd0};
    req_valid_i = 2'b11; core_lat = 2;
    #1;
    check_eq("mr_first_tie", req_ready_o, 2'b01);
    tick();
    req_valid_i = 2'b00;
    wait_rsp(20);
    check_eq("mr_rsp_valid2", rsp_valid_o, 2'b01);
    check_eq("mr_res2", rsp_res_o, 7);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_core_arbiter.md
Name: calc_core_arbiter

Overview:
- Sequences a single shared multi-cycle calculator core and shares it between two requesters.
- Each requester has its own valid/ready request port and its own valid/ready response port.
- Arbitration is round-robin: accept one operation, issue it with a single-cycle start pulse, wait for done or timeout, then return result/remainder to the owning requester.
- Sits between the operand sources and the calculator core, which is instantiated beside it in the calculator top level.

Parameters:
- width, 8: operand width; result and remainder are 2*width.
- timeout, 64: cycles to wait for core_done_i before aborting with an error; must be at least 2.

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_i  in  1  synchronous, active-low reset.
- req_valid_i  in  2  request valid, bit g = requester g.
- req_ready_o  out  2  request accepted this cycle (one-hot or zero).
- req_a_i  in  2*width  operand A; requester g uses slice [g*width +: width].
- req_b_i  in  2*width  operand B; same packing.
- req_op_i  in  4  opcode; requester g uses [2g +: 2].
- core_start_o  out  1  one-cycle start pulse to the core.
- core_a_o  out  width  latched operand A.
- core_b_o  out  width  latched operand B.
- core_op_o  out  2  latched opcode.
- core_done_i  in  1  core completion pulse.
- core_res_i  in  2*width  core result.
- core_rem_i  in  2*width  core remainder.
- rsp_valid_o  out  2  response valid for requester g.
- rsp_ready_i  in  2  response accepted by requester g.
- rsp_res_o  out  2*width  result (shared bus; valid only with rsp_valid_o).
- rsp_rem_o  out  2*width  remainder (shared bus).
- rsp_err_o  out  1  error flag (divide by zero or timeout).
- busy_o  out  1  high in every state except IDLE.

Behaviour:
Reset:
- reset_i low at a rising edge: state becomes IDLE, timeout counter 0.
- Round-robin pointer is set so requester 0 wins the first tie.
- All registered outputs go to 0: core_start_o, core_a_o, core_b_o, core_op_o, rsp_valid_o, rsp_res_o, rsp_rem_o, rsp_err_o, busy_o.
- Reset mid-operation abandons the operation; no response is produced for it.

States:
- IDLE:
  - req_ready_o is combinational: the winner bit is 1 when any req_valid_i is high, otherwise 0.
  - Winner: if only one requester is valid, it wins. If both are valid, the requester not served last wins.
  - On accept, latch the winner's operands, opcode and id.
  - Opcode 3 (DIV) with b == 0 goes to RESP with err=1, res = all ones, rem = zero-extended a. The core is never started.
  - Otherwise go to ISSUE.
- ISSUE:
  - core_start_o = 1 for exactly this cycle.
  - Clear the counter, go to WAIT.
  - core_a_o, core_b_o and core_op_o stay stable from ISSUE through the end of WAIT.
- WAIT:
  - The counter increments each cycle.
  - core_done_i = 1: latch core_res_i and core_rem_i, set err=0, go to RESP.
  - Counter reaching timeout-1 without done: res=0, rem=0, err=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid_o[id] = 1; data and err are held until rsp_ready_i[id] is high.
  - On that handshake: update the pointer to id, go to IDLE.
  - The next accept can occur in the cycle after that handshake.

Rules:
- core_done_i outside WAIT is ignored.
- req_valid_i changes outside IDLE have no effect.
- Response data is the latched value, never a combinational pass-through of core_res_i.

Latency:
- Accept at cycle t, core_start_o high at t+1.
- Core done at t+1+k gives rsp_valid_o at t+2+k.
- Divide-by-zero response: rsp_valid_o at t+1.

Decomposition:
- Shared package calc_pkg holds:
  - Opcode constants: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3.
  - FSM state encoding: IDLE, ISSUE, WAIT, RESP.
  - Default timeout.
- One natural sub-module: rr_arbiter2, a 2-way round-robin grant. Inputs are requests and the last-served id; output is a one-hot grant.
- The FSM, latches and timeout counter stay in calc_core_arbiter.

Test Plan:
- Single request:
  - Stimulus: req0 with a=12, b=5, op=MUL; core done 8 cycles after start with res=60, rem=0.
  - Required: exactly one start pulse; rsp_valid_o=01, res=60, err=0 one cycle after done; busy_o low after the handshake.
- Contention:
  - Stimulus: both valid continuously (req0 ADD 3+4, req1 SUB 9-2).
  - Required: grants alternate 0,1,0,1; responses are 7 to requester 0 and 7 to requester 1, each on the correct rsp_valid_o bit.
- Divide by zero:
  - Stimulus: req1 DIV with a=200, b=0.
  - Required: core_start_o never asserts; rsp_valid_o=10 one cycle after accept; res=16'hFFFF, rem=200, err=1.
- Timeout:
  - Stimulus: req0 DIV 100/7 with core_done_i held low.
  - Required: rsp_valid_o rises timeout cycles after start; res=0, rem=0, err=1. A late done pulse afterwards is ignored.
- Backpressure:
  - Stimulus: rsp_ready_i low for 5 cycles after rsp_valid_o rises, with req1 pending.
  - Required: response data stays stable; req_ready_o stays 00 until the handshake, then grants requester 1.
- Reset mid-operation:
  - Stimulus: reset_i low for 1 cycle during WAIT.
  - Required: next cycle all outputs are 0 and the state is IDLE; a subsequent core_done_i produces no response; with both requesters then valid, requester 0 wins first.
